// File: rtl/udp_rx_fifo_unpacker.sv
// udp_rx_fifo_unpacker: pops one packet from the RX status/byte FIFO pair.
// It checks the 0xA5 header and the length, reassembles the payload into
// nOfFifos words, and writes all words to the downstream FIFOs in one cycle.
module udp_rx_fifo_unpacker #(
    parameter int unsigned AVL_SIZE    = 8,
    parameter int unsigned BYTE_SIZE   = 8,
    parameter int unsigned IP_SIZE     = 32,
    parameter int unsigned MAC_SIZE    = 48,
    parameter int unsigned FIFO_LENGTH = 16,
    parameter int unsigned nOfFifos    = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [AVL_SIZE-1:0]                   rx_fifo_data,
    input  logic                                  rx_fifo_data_empty,
    output logic                                  rx_fifo_data_read,
    input  logic [2*BYTE_SIZE+IP_SIZE+MAC_SIZE-1:0] rx_fifo_status,
    input  logic                                  rx_fifo_status_empty,
    output logic                                  rx_fifo_status_read,
    output logic [nOfFifos-1:0]                   wrreq_fifo,
    output logic [nOfFifos*FIFO_LENGTH-1:0]       wrdata_fifo,
    input  logic [nOfFifos-1:0]                   wrfull_fifo,
    output logic [IP_SIZE-1:0]                    source_ip,
    output logic [MAC_SIZE-1:0]                   source_mac,
    output logic [15:0]                           pkt_ok_count,
    output logic [15:0]                           pkt_drop_count
);

    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned BYTE_IN_FIFO = FIFO_LENGTH / BYTE_W;
    localparam int unsigned EXP_LEN      = nOfFifos * BYTE_IN_FIFO + 1;
    localparam int unsigned LEN_W        = 2 * BYTE_SIZE;
    localparam int unsigned STAT_W       = LEN_W + IP_SIZE + MAC_SIZE;
    localparam int unsigned BC_W         = (BYTE_IN_FIFO > 1) ? $clog2(BYTE_IN_FIFO) : 1;
    localparam int unsigned SEL_W        = (nOfFifos > 1) ? $clog2(nOfFifos) : 1;
    localparam int unsigned WB_W         = $clog2(FIFO_LENGTH);
    localparam int unsigned CNT_W        = 16;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_CHECK,
        RX_HEADER,
        RX_PAYLOAD,
        RX_DISCARD,
        RX_COMMIT
    } rx_state_t;

    rx_state_t              r_state;
    logic [LEN_W-1:0]       r_len;
    logic [LEN_W-1:0]       r_rem;
    logic [IP_SIZE-1:0]     r_ip;
    logic [MAC_SIZE-1:0]    r_mac;
    logic [BC_W-1:0]        r_byte_cnt;
    logic [SEL_W-1:0]       r_fifo_sel;
    logic [FIFO_LENGTH-1:0] r_words [nOfFifos];

    logic                   w_pop;
    logic [LEN_W-1:0]       w_rem_dec;
    logic [WB_W-1:0]        w_hi;

    // Saturating increment for the packet counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // A byte is popped whenever one is available in a byte-consuming state.
    assign w_pop = !rx_fifo_data_empty &&
                   ((r_state == RX_HEADER) || (r_state == RX_PAYLOAD) || (r_state == RX_DISCARD));
    assign rx_fifo_data_read = w_pop;
    assign w_rem_dec = r_rem - LEN_W'(1);
    // MSB-first byte position inside the current word.
    assign w_hi = WB_W'(FIFO_LENGTH - 1 - BYTE_W * 32'(r_byte_cnt));

    // Packet FSM: header/length check, reassembly and all-or-nothing commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state             <= RX_IDLE;
            r_len               <= '0;
            r_rem               <= '0;
            r_ip                <= '0;
            r_mac               <= '0;
            r_byte_cnt          <= '0;
            r_fifo_sel          <= '0;
            for (int i = 0; i < int'(nOfFifos); i++) r_words[i] <= '0;
            rx_fifo_status_read <= 1'b0;
            wrreq_fifo          <= '0;
            wrdata_fifo         <= '0;
            source_ip           <= '0;
            source_mac          <= '0;
            pkt_ok_count        <= '0;
            pkt_drop_count      <= '0;
        end else begin
            rx_fifo_status_read <= 1'b0;
            wrreq_fifo          <= '0;
            case (r_state)
                RX_IDLE: begin
                    if (!rx_fifo_status_empty) begin
                        r_len               <= rx_fifo_status[STAT_W-1 -: LEN_W];
                        r_ip                <= rx_fifo_status[MAC_SIZE +: IP_SIZE];
                        r_mac               <= rx_fifo_status[MAC_SIZE-1:0];
                        rx_fifo_status_read <= 1'b1;
                        r_state             <= RX_CHECK;
                    end
                end
                RX_CHECK: begin
                    if (r_len == '0) begin
                        pkt_drop_count <= sat_inc(pkt_drop_count);
                        r_state        <= RX_IDLE;
                    end else if (r_len != LEN_W'(EXP_LEN)) begin
                        r_rem   <= r_len;
                        r_state <= RX_DISCARD;
                    end else begin
                        r_rem      <= LEN_W'(EXP_LEN);
                        r_byte_cnt <= '0;
                        r_fifo_sel <= '0;
                        r_state    <= RX_HEADER;
                    end
                end
                RX_HEADER: begin
                    if (w_pop) begin
                        r_rem <= w_rem_dec;
                        if (rx_fifo_data == AVL_SIZE'(8'hA5)) begin
                            r_state <= RX_PAYLOAD;
                        end else if (w_rem_dec == '0) begin
                            pkt_drop_count <= sat_inc(pkt_drop_count);
                            r_state        <= RX_IDLE;
                        end else begin
                            r_state <= RX_DISCARD;
                        end
                    end
                end
                RX_PAYLOAD: begin
                    if (w_pop) begin
                        r_rem                       <= w_rem_dec;
                        r_words[r_fifo_sel][w_hi -: BYTE_W] <= rx_fifo_data[BYTE_W-1:0];
                        if (r_byte_cnt == BC_W'(BYTE_IN_FIFO - 1)) begin
                            r_byte_cnt <= '0;
                            if (r_fifo_sel == SEL_W'(nOfFifos - 1)) begin
                                r_state <= RX_COMMIT;
                            end else begin
                                r_fifo_sel <= r_fifo_sel + SEL_W'(1);
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + BC_W'(1);
                        end
                    end
                end
                RX_DISCARD: begin
                    if (w_pop) begin
                        r_rem <= w_rem_dec;
                        if (w_rem_dec == '0) begin
                            pkt_drop_count <= sat_inc(pkt_drop_count);
                            r_state        <= RX_IDLE;
                        end
                    end
                end
                RX_COMMIT: begin
                    if (wrfull_fifo == '0) begin
                        wrreq_fifo <= '1;
                        for (int i = 0; i < int'(nOfFifos); i++) begin
                            wrdata_fifo[FIFO_LENGTH*i +: FIFO_LENGTH] <= r_words[i];
                        end
                        source_ip    <= r_ip;
                        source_mac   <= r_mac;
                        pkt_ok_count <= sat_inc(pkt_ok_count);
                    end else begin
                        pkt_drop_count <= sat_inc(pkt_drop_count);
                    end
                    r_state <= RX_IDLE;
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_rx_fifo_unpacker.sv
// Directed bench for udp_rx_fifo_unpacker with modelled show-ahead RX FIFOs
// and a scoreboard of expected downstream writes.
module tb_udp_rx_fifo_unpacker;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_fifo_data;
    logic        rx_fifo_data_empty;
    logic        rx_fifo_data_read;
    logic [95:0] rx_fifo_status;
    logic        rx_fifo_status_empty;
    logic        rx_fifo_status_read;
    logic [3:0]  wrreq_fifo;
    logic [63:0] wrdata_fifo;
    logic [3:0]  wrfull_fifo;
    logic [31:0] source_ip;
    logic [47:0] source_mac;
    logic [15:0] pkt_ok_count;
    logic [15:0] pkt_drop_count;

    udp_rx_fifo_unpacker dut (
        .clk                  (clk),
        .reset                (reset),
        .rx_fifo_data         (rx_fifo_data),
        .rx_fifo_data_empty   (rx_fifo_data_empty),
        .rx_fifo_data_read    (rx_fifo_data_read),
        .rx_fifo_status       (rx_fifo_status),
        .rx_fifo_status_empty (rx_fifo_status_empty),
        .rx_fifo_status_read  (rx_fifo_status_read),
        .wrreq_fifo           (wrreq_fifo),
        .wrdata_fifo          (wrdata_fifo),
        .wrfull_fifo          (wrfull_fifo),
        .source_ip            (source_ip),
        .source_mac           (source_mac),
        .pkt_ok_count         (pkt_ok_count),
        .pkt_drop_count       (pkt_drop_count)
    );

    always #4 clk = ~clk;

    logic [7:0]  bq[$];
    logic [95:0] sq[$];
    logic [63:0] exp_q[$];
    logic        stall;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_dpop = 0;
    int          n_spop = 0;
    int          n_wr = 0;
    logic [63:0] sb_exp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present the FIFO heads to the DUT.
    task automatic refresh();
        rx_fifo_data_empty   = (bq.size() == 0) || stall;
        rx_fifo_data         = (bq.size() != 0) ? bq[0] : 8'h00;
        rx_fifo_status_empty = (sq.size() == 0);
        rx_fifo_status       = (sq.size() != 0) ? sq[0] : 96'h0;
    endtask

    // One clock: sample pops mid-cycle, apply them just after the edge.
    task automatic tick();
        logic pd, ps;
        @(negedge clk);
        pd = rx_fifo_data_read;
        ps = rx_fifo_status_read;
        if (stall) chk("no_pop_while_empty", 64'(pd), 64'h0);
        @(posedge clk);
        #1;
        if (pd === 1'b1) begin
            n_dpop++;
            if (bq.size() != 0) void'(bq.pop_front());
        end
        if (ps === 1'b1) begin
            n_spop++;
            if (sq.size() != 0) void'(sq.pop_front());
        end
        refresh();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Valid packet whose expected wrdata layout is given directly.
    task automatic push_valid(input logic [31:0] ip, input logic [47:0] mac,
                              input logic [63:0] flat, input bit expect_write);
        logic [15:0] w;
        sq.push_back({16'd9, ip, mac});
        bq.push_back(8'hA5);
        for (int i = 0; i < 4; i++) begin
            w = flat[16*i +: 16];
            bq.push_back(w[15:8]);
            bq.push_back(w[7:0]);
        end
        if (expect_write) exp_q.push_back(flat);
        refresh();
    endtask

    task automatic push_raw(input logic [15:0] len, input logic [31:0] ip,
                            input logic [47:0] mac, input logic [7:0] first, input int nb);
        sq.push_back({len, ip, mac});
        for (int i = 0; i < nb; i++) bq.push_back(first + 8'(i));
        refresh();
    endtask

    task automatic wait_pops(input int target, input string tag);
        int c = 0;
        while (n_dpop < target && c < 100) begin
            tick();
            c++;
        end
        chk(tag, 64'(n_dpop), 64'(target));
    endtask

    // Scoreboard: every downstream write must match the next expected word set.
    always @(negedge clk) begin
        if (reset === 1'b0 && wrreq_fifo !== 4'h0) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                chk("unexpected_wrreq", 64'(wrreq_fifo), 64'h0);
            end else begin
                sb_exp = exp_q.pop_front();
                chk("wrreq_all", 64'(wrreq_fifo), 64'hF);
                chk("wrdata", wrdata_fifo, sb_exp);
            end
        end
    end

    initial begin
        int p0, w0, s0;
        reset = 1'b1;
        stall = 1'b0;
        wrfull_fifo = 4'h0;
        refresh();
        ticks(3);
        chk("rst_status_read", 64'(rx_fifo_status_read), 64'h0);
        chk("rst_data_read", 64'(rx_fifo_data_read), 64'h0);
        chk("rst_wrreq", 64'(wrreq_fifo), 64'h0);
        chk("rst_wrdata", wrdata_fifo, 64'h0);
        chk("rst_ip", 64'(source_ip), 64'h0);
        chk("rst_mac", 64'(source_mac), 64'h0);
        chk("rst_ok", 64'(pkt_ok_count), 64'h0);
        chk("rst_drop", 64'(pkt_drop_count), 64'h0);
        reset = 1'b0;
        ticks(2);

        // Basic valid packet.
        p0 = n_dpop; w0 = n_wr;
        push_valid(32'hC0A8_0001, 48'h0011_2233_4455, 64'hDEF0_9ABC_5678_1234, 1'b1);
        ticks(25);
        chk("t1_pops", 64'(n_dpop - p0), 64'd9);
        chk("t1_writes", 64'(n_wr - w0), 64'd1);
        chk("t1_ok", 64'(pkt_ok_count), 64'd1);
        chk("t1_drop", 64'(pkt_drop_count), 64'd0);
        chk("t1_ip", 64'(source_ip), 64'hC0A8_0001);
        chk("t1_mac", 64'(source_mac), 64'h0011_2233_4455);
        chk("t1_wrdata_hold", wrdata_fifo, 64'hDEF0_9ABC_5678_1234);

        // Bad header byte, then a good packet.
        p0 = n_dpop; w0 = n_wr;
        push_raw(16'd9, 32'hC0A8_0002, 48'hAAAA_BBBB_CCCC, 8'h5A, 1);
        push_raw(16'd0, 32'h0, 48'h0, 8'h00, 0);
        void'(sq.pop_back());
        for (int i = 0; i < 8; i++) bq.push_back(8'h10 + 8'(i));
        refresh();
        ticks(25);
        chk("t2_pops", 64'(n_dpop - p0), 64'd9);
        chk("t2_writes", 64'(n_wr - w0), 64'd0);
        chk("t2_drop", 64'(pkt_drop_count), 64'd1);
        chk("t2_ip_kept", 64'(source_ip), 64'hC0A8_0001);
        push_valid(32'hC0A8_0003, 48'h0102_0304_0506, 64'h4444_3333_2222_1111, 1'b1);
        ticks(25);
        chk("t2_ok", 64'(pkt_ok_count), 64'd2);
        chk("t2_ip_new", 64'(source_ip), 64'hC0A8_0003);

        // Wrong length, then zero length.
        p0 = n_dpop; w0 = n_wr;
        push_raw(16'd5, 32'hC0A8_0004, 48'h1, 8'hA5, 5);
        ticks(20);
        chk("t3_pops", 64'(n_dpop - p0), 64'd5);
        chk("t3_drop", 64'(pkt_drop_count), 64'd2);
        p0 = n_dpop; s0 = n_spop;
        push_raw(16'd0, 32'hC0A8_0005, 48'h2, 8'h00, 0);
        ticks(10);
        chk("t3_zero_pops", 64'(n_dpop - p0), 64'd0);
        chk("t3_zero_spop", 64'(n_spop - s0), 64'd1);
        chk("t3_zero_drop", 64'(pkt_drop_count), 64'd3);
        chk("t3_writes", 64'(n_wr - w0), 64'd0);

        // Downstream full at commit.
        w0 = n_wr;
        wrfull_fifo = 4'b0100;
        push_valid(32'hC0A8_0006, 48'h3, 64'h0F0F_F0F0_AAAA_5555, 1'b0);
        ticks(25);
        wrfull_fifo = 4'h0;
        chk("t4_writes", 64'(n_wr - w0), 64'd0);
        chk("t4_drop", 64'(pkt_drop_count), 64'd4);
        chk("t4_ok", 64'(pkt_ok_count), 64'd2);
        chk("t4_ip_kept", 64'(source_ip), 64'hC0A8_0003);

        // Byte FIFO runs dry mid-payload.
        p0 = n_dpop; w0 = n_wr;
        push_valid(32'hC0A8_0007, 48'h4, 64'hDEF0_9ABC_5678_1234, 1'b1);
        wait_pops(p0 + 3, "t5_reach_payload");
        stall = 1'b1;
        refresh();
        ticks(3);
        chk("t5_stalled_pops", 64'(n_dpop - p0), 64'd3);
        stall = 1'b0;
        refresh();
        ticks(25);
        chk("t5_pops", 64'(n_dpop - p0), 64'd9);
        chk("t5_writes", 64'(n_wr - w0), 64'd1);
        chk("t5_ok", 64'(pkt_ok_count), 64'd3);
        chk("t5_ip", 64'(source_ip), 64'hC0A8_0007);

        // Reset after four payload bytes.
        p0 = n_dpop; w0 = n_wr;
        push_valid(32'hC0A8_0008, 48'h5, 64'h1357_2468_ACE0_BDF1, 1'b0);
        wait_pops(p0 + 5, "t6_reach_mid");
        reset = 1'b1;
        tick();
        chk("t6_rst_data_read", 64'(rx_fifo_data_read), 64'h0);
        chk("t6_rst_wrreq", 64'(wrreq_fifo), 64'h0);
        chk("t6_rst_wrdata", wrdata_fifo, 64'h0);
        chk("t6_rst_ip", 64'(source_ip), 64'h0);
        chk("t6_rst_ok", 64'(pkt_ok_count), 64'h0);
        chk("t6_rst_drop", 64'(pkt_drop_count), 64'h0);
        bq.delete();
        reset = 1'b0;
        refresh();
        ticks(2);
        push_valid(32'hC0A8_0009, 48'h6, 64'h8765_4321_FEDC_BA98, 1'b1);
        ticks(25);
        chk("t6_writes", 64'(n_wr - w0), 64'd1);
        chk("t6_ok", 64'(pkt_ok_count), 64'd1);
        chk("t6_ip", 64'(source_ip), 64'hC0A8_0009);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
